// File: rtl/fetch_pkg.sv
// Shared fetch-side constants: default widths, reset PC and the NOP encoding.
// Imported by the prefetch queue and its FIFO.
package fetch_pkg;

  localparam int          PC_WIDTH   = 32;
  localparam int          INST_WIDTH = 32;
  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// In-order DEPTH x W FIFO with push, pop, clear and a registered head.
// Ports: clk, rst, push_i/data_i, pop_i, clear_i, count_o, valid_o, head_o.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output logic [W-1:0]  head_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign count_o = cnt_q;
  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch prefetch queue: credit-limited imem requests, in-order response
// queue with PCs, drop of stale responses after a redirect.
// Ports: clk, rst; imem_req_{valid,addr,ready}; imem_rsp_{valid,data};
// redirect_{valid,pc}; out_{valid,pc,inst,ready}.
module instr_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH   = fetch_pkg::PC_WIDTH,
  parameter int INST_WIDTH = fetch_pkg::INST_WIDTH,
  parameter int DEPTH      = fetch_pkg::DEPTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC =
    PC_WIDTH'(fetch_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  input  logic                  out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = PC_WIDTH + INST_WIDTH;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [CW-1:0]       drop_q, drop_d;
  logic [CW-1:0]       fifo_cnt;
  logic [CW:0]         inflight;
  logic [W-1:0]        head;
  logic                accept;
  logic                keep;
  logic                pop;

  // outstanding + queued never exceeds DEPTH, so pushes cannot overflow
  assign inflight = {1'b0, outst_q} + {1'b0, fifo_cnt};

  assign imem_req_valid = !rst && !redirect_valid &&
                          (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign accept = imem_req_valid && imem_req_ready;
  assign keep   = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop    = out_valid && out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(accept) - CW'(imem_rsp_valid);
    if (accept) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
    end
    if (imem_rsp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end else begin
        rsp_pc_d = rsp_pc_q + PC_WIDTH'(1);
      end
    end
    // everything still in flight after this cycle belongs to the old path
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      assert (!(imem_rsp_valid && (outst_q == '0)));
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (keep),
    .data_i  ({rsp_pc_q, imem_rsp_data}),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .count_o (fifo_cnt),
    .valid_o (out_valid),
    .head_o  (head)
  );

  assign out_pc   = head[W-1:INST_WIDTH];
  assign out_inst = head[INST_WIDTH-1:0];

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a variable-latency imem model.
// A second instance checks PC wrap from a high reset PC.
module tb_instr_prefetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, rsp_valid;
  logic [31:0] req_addr, rsp_data;
  logic        redir_v, out_valid, out_ready;
  logic [31:0] redir_pc, out_pc, out_inst;

  logic        rst1, req_valid1, rsp_valid1, out_valid1;
  logic [31:0] req_addr1, rsp_data1, out_pc1, out_inst1;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  int cyc   = 0;
  int nreq;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;
  pend_t q0[$];

  logic        acc1;
  logic [31:0] a1;

  instr_prefetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr),
    .imem_req_ready(req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready)
  );

  instr_prefetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut1 (
    .clk(clk), .rst(rst1),
    .imem_req_valid(req_valid1), .imem_req_addr(req_addr1),
    .imem_req_ready(1'b1),
    .imem_rsp_valid(rsp_valid1), .imem_rsp_data(rsp_data1),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid1), .out_pc(out_pc1), .out_inst(out_inst1),
    .out_ready(1'b1)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // in-order memory: request accepted at edge e answers lat cycles later
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
    end else begin
      if (rsp_valid) void'(q0.pop_front());
      if (req_valid && req_ready) q0.push_back('{req_addr, cyc + lat});
    end
    cyc++;
    #1;
    if (!rst && q0.size() > 0 && q0[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = f(q0[0].a);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
  end

  always @(posedge clk) begin
    acc1 = !rst1 && req_valid1;
    a1   = req_addr1;
    #1;
    rsp_valid1 = acc1;
    rsp_data1  = f(a1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input int budget, input bit which);
    logic v = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      v = which ? out_valid1 : out_valid;
      if (v) break;
    end
    chk({tag, "_valid"}, {31'b0, v}, 32'h1);
    if (v) begin
      chk({tag, "_pc"}, which ? out_pc1 : out_pc, pc);
      chk({tag, "_inst"}, which ? out_inst1 : out_inst, f(pc));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; req_ready = 1'b1;
    redir_v = 1'b0; redir_pc = 32'h0; out_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = 32'h0;
    rsp_valid1 = 1'b0; rsp_data1 = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);

    // 1: latency 1, continuous stream
    rst = 1'b0;
    #1;
    chk("t1_req_valid", {31'b0, req_valid}, 32'h1);
    chk("t1_req_addr", req_addr, 32'h0);
    @(negedge clk);
    chk("t1_c1_out_valid", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 6; i++) expect_out("t1_seq", 32'(i), 1, 1'b0);

    // 2: decode stalled, credit limit
    do_reset();
    out_ready = 1'b0;
    rst = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_valid && req_ready) nreq++;
      @(negedge clk);
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk("t2_req_valid", {31'b0, req_valid}, 32'h0);
    chk("t2_hold_valid", {31'b0, out_valid}, 32'h1);
    chk("t2_hold_pc", out_pc, 32'h0);
    chk("t2_hold_inst", out_inst, f(32'h0));
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) expect_out("t2_drain", 32'(i), 1, 1'b0);

    // 3: latency 3, redirect with 3 outstanding
    do_reset();
    lat = 3;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    redir_v = 1'b1; redir_pc = 32'h40;
    #1;
    chk("t3_req_gated", {31'b0, req_valid}, 32'h0);
    @(negedge clk);
    redir_v = 1'b0;
    #1;
    chk("t3_req_valid", {31'b0, req_valid}, 32'h1);
    chk("t3_req_addr", req_addr, 32'h40);
    chk("t3_out_valid", {31'b0, out_valid}, 32'h0);
    chk("t3_drop", 32'(dut.drop_q), 32'd2);
    expect_out("t3_a", 32'h40, 10, 1'b0);
    expect_out("t3_b", 32'h41, 4, 1'b0);
    expect_out("t3_c", 32'h42, 4, 1'b0);

    // 4: redirect coincides with a response
    do_reset();
    lat = 2;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    redir_v = 1'b1; redir_pc = 32'h100;
    #1;
    chk("t4_rsp_in_R", {31'b0, rsp_valid}, 32'h1);
    @(negedge clk);
    redir_v = 1'b0;
    #1;
    chk("t4_req_addr", req_addr, 32'h100);
    chk("t4_req_valid", {31'b0, req_valid}, 32'h1);
    chk("t4_drop", 32'(dut.drop_q), 32'd1);
    expect_out("t4_a", 32'h100, 10, 1'b0);
    expect_out("t4_b", 32'h101, 4, 1'b0);

    // 6: reset mid-stream with 2 outstanding
    do_reset();
    lat = 3;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_req_in_rst", {31'b0, req_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_out_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_out_pc", out_pc, 32'h0);
    chk("t6_drop", 32'(dut.drop_q), 32'd0);
    chk("t6_outst", 32'(dut.outst_q), 32'd0);
    chk("t6_req_addr", req_addr, 32'h0);
    expect_out("t6_a", 32'h0, 10, 1'b0);
    expect_out("t6_b", 32'h1, 4, 1'b0);

    // 5: PC wrap on the high-reset-PC instance
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("t5_req_addr", req_addr1, 32'hFFFF_FFFE);
    expect_out("t5_a", 32'hFFFF_FFFE, 4, 1'b1);
    expect_out("t5_b", 32'hFFFF_FFFF, 1, 1'b1);
    expect_out("t5_c", 32'h0, 1, 1'b1);
    expect_out("t5_d", 32'h1, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
